// File: rtl/dec_pkg.sv
// dec_pkg: shared widths, mode/error enums and codeword helpers for the SEC-DED decoder
package dec_pkg;
    localparam int MAX_CODEWORD_WIDTH = 32;
    localparam int MAX_INFO_WIDTH = 26;
    localparam int CW_8_4 = 8;
    localparam int IW_8_4 = 4;
    localparam int CW_16_11 = 16;
    localparam int IW_16_11 = 11;
    localparam int CW_32_26 = 32;
    localparam int IW_32_26 = 26;

    typedef enum logic [1:0] {MODE_RSV, MODE_8_4, MODE_16_11, MODE_32_26} work_mode_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_CORR, ERR_UNCORR, ERR_RSV} err_code_t;

    function automatic logic [MAX_CODEWORD_WIDTH-1:0] cw_mask(work_mode_t m);
        logic [MAX_CODEWORD_WIDTH-1:0] ones;
        ones = '1;
        return m == MODE_8_4   ? ones >> (MAX_CODEWORD_WIDTH - CW_8_4) :
               m == MODE_16_11 ? ones >> (MAX_CODEWORD_WIDTH - CW_16_11) :
               m == MODE_32_26 ? ones >> (MAX_CODEWORD_WIDTH - CW_32_26) : '0;
    endfunction

    // Info bits sit at the non-power-of-two positions in ascending order, so a
    // masked word extracts correctly for every mode with the same bit map.
    function automatic logic [MAX_INFO_WIDTH-1:0] extract(logic [MAX_CODEWORD_WIDTH-1:0] cw);
        logic [MAX_INFO_WIDTH-1:0] d;
        logic [4:0] j;
        d = '0;
        j = '0;
        for (int i = 3; i < MAX_CODEWORD_WIDTH; i++)
            if ((i & (i - 1)) != 0) begin
                d[j] = cw[i[4:0]];
                j = j + 5'd1;
            end
        return d;
    endfunction
endpackage

// File: rtl/dec_correct_if.sv
// dec_correct_if: codeword-in / info-out valid-ready bundle plus error counters
interface dec_correct_if;
    import dec_pkg::*;
    logic [MAX_CODEWORD_WIDTH-1:0] data_in;
    logic [1:0] work_mod;
    logic in_valid;
    logic in_ready;
    logic [MAX_INFO_WIDTH-1:0] data_out;
    logic [1:0] num_of_errors;
    logic out_valid;
    logic out_ready;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

    modport master (output data_in, work_mod, in_valid, out_ready,
                    input in_ready, data_out, num_of_errors, out_valid, corr_cnt, uncorr_cnt);
    modport slave (input data_in, work_mod, in_valid, out_ready,
                   output in_ready, data_out, num_of_errors, out_valid, corr_cnt, uncorr_cnt);
endinterface

// File: rtl/dec_syndrome.sv
// dec_syndrome: Hamming syndrome and overall parity of a masked codeword
module dec_syndrome
    import dec_pkg::*;
(
    input  logic [MAX_CODEWORD_WIDTH-1:0] cw,
    output logic [4:0] syn,
    output logic par
);
    always_comb begin
        syn = '0;
        for (int i = 1; i < MAX_CODEWORD_WIDTH; i++) syn = syn ^ (cw[i[4:0]] ? i[4:0] : 5'd0);
        par = ^cw;
    end
endmodule

// File: rtl/dec_correct.sv
// dec_correct: two-stage pipelined SEC-DED decoder for (8,4)/(16,11)/(32,26) extended Hamming.
// Define DEC_ERR_CNT_EN to add saturating corrected/uncorrectable word counters.
module dec_correct
    import dec_pkg::*;
(
    input logic clk,
    input logic rst,
    dec_correct_if.slave bus
);
    logic a_valid, a_par, b_valid, a_adv, b_adv, p_w;
    logic [MAX_CODEWORD_WIDTH-1:0] a_data, in_masked, fixed;
    logic [4:0] a_syn, s_w;
    work_mode_t a_mode, in_mode;
    err_code_t err, b_err;
    logic [MAX_INFO_WIDTH-1:0] info, b_data;

    assign in_mode = work_mode_t'(bus.work_mod);
    assign in_masked = bus.data_in & cw_mask(in_mode);
    assign b_adv = !b_valid || bus.out_ready;
    assign a_adv = !a_valid || b_adv;
    assign bus.in_ready = a_adv;
    assign bus.out_valid = b_valid;
    assign bus.data_out = b_data;
    assign bus.num_of_errors = b_err;

    dec_syndrome u_syn (.cw(in_masked), .syn(s_w), .par(p_w));

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            a_valid <= 1'b0;
            a_data <= '0;
            a_mode <= MODE_RSV;
            a_syn <= '0;
            a_par <= 1'b0;
        end else if (a_adv) begin
            a_valid <= bus.in_valid;
            if (bus.in_valid) begin
                a_data <= in_masked;
                a_mode <= in_mode;
                a_syn <= s_w;
                a_par <= p_w;
            end
        end

    // A zero syndrome with odd parity is a bit-0 error, which never touches info;
    // reserved mode masks the word to zero, so its extraction is already zero.
    always_comb begin
        fixed = a_data ^ ((a_par && a_syn != 5'd0) ? MAX_CODEWORD_WIDTH'(1) << a_syn : '0);
        err = a_mode == MODE_RSV ? ERR_RSV : a_par ? ERR_CORR : a_syn != 5'd0 ? ERR_UNCORR : ERR_NONE;
        info = extract(fixed);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            b_valid <= 1'b0;
            b_data <= '0;
            b_err <= ERR_NONE;
        end else if (b_adv) begin
            b_valid <= a_valid;
            if (a_valid) begin
                b_data <= info;
                b_err <= err;
            end
        end

`ifdef DEC_ERR_CNT_EN
    logic [15:0] corr, uncorr;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            corr <= '0;
            uncorr <= '0;
        end else if (b_valid && bus.out_ready) begin
            if (b_err == ERR_CORR && corr != 16'hFFFF) corr <= corr + 16'd1;
            if (b_err == ERR_UNCORR && uncorr != 16'hFFFF) uncorr <= uncorr + 16'd1;
        end

    assign bus.corr_cnt = corr;
    assign bus.uncorr_cnt = uncorr;
`else
    assign bus.corr_cnt = '0;
    assign bus.uncorr_cnt = '0;
`endif
endmodule

// File: tb/tb_dec_correct.sv
// tb_dec_correct: vector table, stall/reset sequences and randomized scoreboard for dec_correct
module tb_dec_correct;
    import dec_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dec_correct_if bus ();
    dec_correct dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [1:0] mode;
        logic [31:0] data;
        logic [25:0] exp_out;
        logic [1:0] exp_err;
    } vec_t;

    vec_t vecs[10];
    vec_t w[8];
    vec_t q[$];
    vec_t v, e;
    int total = 0, bad = 0, mc = 0, mu = 0;
    int sent, got, cyc;
    logic held_v;
    logic [25:0] held_d;
    logic [1:0] held_e;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic note(logic [1:0] ec);
        if (ec == 2'd1 && mc < 65535) mc++;
        if (ec == 2'd2 && mu < 65535) mu++;
    endtask

    task automatic check_cnt(string tag);
`ifdef DEC_ERR_CNT_EN
        check({tag, " corr_cnt"}, {16'd0, bus.corr_cnt}, mc);
        check({tag, " uncorr_cnt"}, {16'd0, bus.uncorr_cnt}, mu);
`else
        check({tag, " corr_cnt"}, {16'd0, bus.corr_cnt}, 0);
        check({tag, " uncorr_cnt"}, {16'd0, bus.uncorr_cnt}, 0);
`endif
    endtask

    function automatic int cw_len(logic [1:0] m);
        return m == 2'd1 ? 8 : m == 2'd2 ? 16 : 32;
    endfunction

    function automatic int info_len(logic [1:0] m);
        return m == 2'd1 ? 4 : m == 2'd2 ? 11 : 26;
    endfunction

    // Extended Hamming encoder written straight from the layout rules.
    function automatic logic [31:0] encode(logic [1:0] m, logic [25:0] info);
        logic [31:0] cw;
        logic b;
        int n, j;
        cw = '0;
        n = cw_len(m);
        j = 0;
        for (int i = 3; i < n; i++)
            if ((i & (i - 1)) != 0) begin
                cw[i] = info[j];
                j++;
            end
        for (int k = 1; k < n; k = k * 2) begin
            b = 1'b0;
            for (int i = 1; i < n; i++) if ((i & k) != 0 && i != k) b = b ^ cw[i];
            cw[k] = b;
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic logic [25:0] extract_ref(logic [1:0] m, logic [31:0] cw);
        logic [25:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 3; i < cw_len(m); i++)
            if ((i & (i - 1)) != 0) begin
                d[j] = cw[i];
                j++;
            end
        return d;
    endfunction

    // Builds a word with a known number of injected errors; the expected error
    // code comes from the injection count, not from any syndrome arithmetic.
    function automatic vec_t make_word(logic [1:0] m, int nerr, logic junk);
        vec_t r;
        logic [25:0] info;
        int n, a, b;
        r.mode = m;
        if (m == 2'd0) begin
            r.data = $urandom;
            r.exp_out = '0;
            r.exp_err = 2'd3;
            return r;
        end
        n = cw_len(m);
        info = 26'($urandom) & 26'((1 << info_len(m)) - 1);
        r.data = encode(m, info);
        a = $urandom_range(0, n - 1);
        b = (a + $urandom_range(1, n - 1)) % n;
        if (nerr >= 1) r.data[a] = ~r.data[a];
        if (nerr == 2) r.data[b] = ~r.data[b];
        r.exp_out = nerr == 2 ? extract_ref(m, r.data) : info;
        r.exp_err = 2'(nerr);
        if (junk && n < 32) r.data = r.data | ($urandom << n);
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.data_in = '0;
        bus.work_mod = 2'd0;
        repeat (2) step();
        check("rst out_valid", bus.out_valid, 0);
        check("rst data_out", bus.data_out, 0);
        check("rst num_of_errors", bus.num_of_errors, 0);
        check_cnt("rst");
        rst = 1'b1;
        step();
        check("in_ready after release", bus.in_ready, 1);

        vecs[0] = '{2'd1, 32'h0000_00AA, 26'hB, 2'd0};
        vecs[1] = '{2'd1, 32'h0000_008A, 26'hB, 2'd1};
        vecs[2] = '{2'd1, 32'h0000_0088, 26'h9, 2'd2};
        vecs[3] = '{2'd3, 32'h0000_0001, 26'h0, 2'd1};
        vecs[4] = '{2'd3, 32'h0000_0000, 26'h0, 2'd0};
        vecs[5] = '{2'd0, 32'h5A5A_5A5A, 26'h0, 2'd3};
        vecs[6] = '{2'd1, 32'hFFFF_FFAA, 26'hB, 2'd0};
        vecs[7] = '{2'd2, 32'h0000_0001, 26'h0, 2'd1};
        vecs[8] = '{2'd2, encode(2'd2, 26'h5A5) ^ 32'h0000_2000, 26'h5A5, 2'd1};
        vecs[9] = '{2'd3, encode(2'd3, 26'h2AA_AAAA) ^ 32'h8000_0001, 26'h0AA_AAAA, 2'd2};

        foreach (vecs[i]) begin
            bus.work_mod = vecs[i].mode;
            bus.data_in = vecs[i].data;
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            check($sformatf("v%0d early out_valid", i), bus.out_valid, 0);
            step();
            check($sformatf("v%0d out_valid", i), bus.out_valid, 1);
            check($sformatf("v%0d data_out", i), bus.data_out, vecs[i].exp_out);
            check($sformatf("v%0d num_of_errors", i), bus.num_of_errors, vecs[i].exp_err);
            if (bus.out_valid) note(vecs[i].exp_err);
            step();
        end
        check_cnt("table");

        for (int i = 0; i < 8; i++) w[i] = make_word(2'(i % 3 + 1), i % 3, 1'b0);
        sent = 0;
        got = 0;
        cyc = 0;
        held_v = 1'b0;
        while (got < 8 && cyc < 100) begin
            bus.in_valid = sent < 8;
            if (sent < 8) begin
                bus.work_mod = w[sent].mode;
                bus.data_in = w[sent].data;
            end
            bus.out_ready = !(cyc >= 3 && cyc < 6);
            #1;
            if (cyc == 3) check("stall in_ready low", bus.in_ready, 0);
            if (held_v) begin
                check("stall hold data_out", bus.data_out, held_d);
                check("stall hold num_of_errors", bus.num_of_errors, held_e);
            end
            held_v = bus.out_valid && !bus.out_ready;
            held_d = bus.data_out;
            held_e = bus.num_of_errors;
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("stream w%0d data_out", got), bus.data_out, w[got].exp_out);
                check($sformatf("stream w%0d num_of_errors", got), bus.num_of_errors, w[got].exp_err);
                note(w[got].exp_err);
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("stream words received", got, 8);
        step();
        check("stream no duplicate", bus.out_valid, 0);

        bus.work_mod = 2'd1;
        bus.data_in = 32'h0000_00AA;
        bus.in_valid = 1'b1;
        step();
        bus.data_in = 32'h0000_008A;
        step();
        bus.in_valid = 1'b0;
        check("pre-reset out_valid", bus.out_valid, 1);
        rst = 1'b0;
        #1;
        check("async reset out_valid", bus.out_valid, 0);
        mc = 0;
        mu = 0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("post-reset idle %0d", i), bus.out_valid, 0);
        end
        check_cnt("reset");

        for (int c = 0; c < 800; c++) begin
            v = make_word(2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            bus.work_mod = v.mode;
            bus.data_in = v.data;
            bus.in_valid = $urandom_range(0, 3) != 0;
            bus.out_ready = $urandom_range(0, 3) != 0;
            #1;
            check("rand in_ready", bus.in_ready, !(q.size() == 2 && !bus.out_ready));
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rand spurious output: got %0h expected none", bus.data_out);
                end else begin
                    e = q.pop_front();
                    check("rand data_out", bus.data_out, e.exp_out);
                    check("rand num_of_errors", bus.num_of_errors, e.exp_err);
                    note(e.exp_err);
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(v);
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid && q.size() > 0) begin
                e = q.pop_front();
                check("drain data_out", bus.data_out, e.exp_out);
                check("drain num_of_errors", bus.num_of_errors, e.exp_err);
                note(e.exp_err);
            end
            step();
        end
        check("drain scoreboard empty", q.size(), 0);
        check("drain out_valid", bus.out_valid, 0);
        check_cnt("random");

`ifdef DEC_ERR_CNT_EN
        bus.work_mod = 2'd3;
        bus.data_in = 32'h0000_0001;
        bus.in_valid = 1'b1;
        repeat (65540) step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        check("saturated corr_cnt", {16'd0, bus.corr_cnt}, 32'hFFFF);
        check("uncorr_cnt unaffected", {16'd0, bus.uncorr_cnt}, mu);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
